pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the stall and flush controls of the IF, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves, in fixed priority, four hazard sources:
- exceptions from MEM;
- multi-cycle divide occupancy in EX;
- load-use hazards in ID;
- taken branches/jumps resolved in ID.

It holds a small FSM and a divide cycle counter, so the pipeline registers stay pure storage.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipe_div_timer.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_pkg
//  Purpose  : Shared types and constants for the pipeline hazard sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // Sequencer states; encoding is fixed so debug probes read consistently.
    typedef enum logic [1:0] {
        RUN = 2'd0,
        DIV = 2'd1,
        EXC = 2'd2
    } hz_state_t;

    // Default register-address width of the integer register file.
    localparam int c_reg_aw_default = 5;

    // Architectural zero register; never a real dependency source.
    localparam int c_zero_reg = 0;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_div_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_div_timer
//  Purpose  : Divide occupancy counter. Loaded with DIV_CYCLES-1 when a
//             divide starts, counts down while the divide is held in EX,
//             and is forced to zero when an exception aborts the divide.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_div_timer #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    input  logic abort,
    output logic cnt_zero
);

    localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Abort beats load so an exception in the start cycle leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (abort) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= C_LOAD_VAL;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign cnt_zero = (r_cnt == '0);

endmodule : pipe_div_timer
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for the 5-stage pipeline.
//             Priority per cycle: MEM exception > EX divide > ID load-use >
//             ID taken branch. All controls are combinational from the
//             state, the divide counter and the hazard inputs.
//  Options  : PIPE_HAZARD_PERF_EN - enables the stall/flush perf counters;
//             when undefined the counter ports are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int REG_AW     = c_reg_aw_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rtE,
    input  logic              memtoregE,
    input  logic              divstartE,
    input  logic              branch_takenD,
    input  logic              excM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              exc_redirect,
    output logic              div_done,
    output logic              busy,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [REG_AW-1:0] C_ZERO = REG_AW'(c_zero_reg);

    hz_state_t r_state;
    hz_state_t w_state_nx;

    logic w_load_use;
    logic w_lower_en;
    logic w_div_load;
    logic w_div_dec;
    logic w_div_abort;
    logic w_cnt_zero;

    // Divide occupancy counter.
    pipe_div_timer #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_div_load),
        .dec      (w_div_dec),
        .abort    (w_div_abort),
        .cnt_zero (w_cnt_zero)
    );

    // A load in EX whose destination feeds either ID source must stall ID.
    assign w_load_use = memtoregE && (rtE != C_ZERO) &&
                        ((rtE == rsD) || (rtE == rtD));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and pipeline controls; reset forces every control low.
    always_comb begin
        w_state_nx   = r_state;
        w_div_load   = 1'b0;
        w_div_dec    = 1'b0;
        w_div_abort  = 1'b0;
        w_lower_en   = 1'b0;
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        exc_redirect = 1'b0;
        div_done     = 1'b0;
        busy         = 1'b0;

        if (!rst) begin
            busy = (r_state != RUN);
            if (excM) begin
                // Exception flushes everything younger and kills any divide.
                flushD       = 1'b1;
                flushE       = 1'b1;
                flushM       = 1'b1;
                exc_redirect = (r_state == EXC);
                w_div_abort  = 1'b1;
                w_state_nx   = EXC;
            end else begin
                case (r_state)
                    RUN: begin
                        if (divstartE) begin
                            stallF     = 1'b1;
                            stallD     = 1'b1;
                            stallE     = 1'b1;
                            flushM     = 1'b1;
                            w_div_load = 1'b1;
                            w_state_nx = DIV;
                        end else begin
                            w_lower_en = 1'b1;
                        end
                    end
                    DIV: begin
                        if (!w_cnt_zero) begin
                            // Same divide still held in EX; divstartE ignored.
                            stallF    = 1'b1;
                            stallD    = 1'b1;
                            stallE    = 1'b1;
                            flushM    = 1'b1;
                            w_div_dec = 1'b1;
                        end else begin
                            // Release cycle: lower hazards resolve normally.
                            div_done   = 1'b1;
                            w_lower_en = 1'b1;
                            w_state_nx = RUN;
                        end
                    end
                    EXC: begin
                        exc_redirect = 1'b1;
                        flushD       = 1'b1;
                        w_state_nx   = RUN;
                    end
                    default: begin
                        w_state_nx = RUN;
                    end
                endcase

                if (w_lower_en) begin
                    if (w_load_use) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end else if (branch_takenD) begin
                        // Branch only redirects when IF/ID is not held.
                        flushD = 1'b1;
                    end
                end
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Free-running stall/flush event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (stallF) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (flushD || flushE || flushM) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed self-checking bench for pipe_hazard_ctrl
//             (DIV_CYCLES=4). Controls are compared as one packed vector
//             {stallF,stallD,stallE,flushD,flushE,flushM,exc_redirect,
//              div_done,busy}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int DIV_CYCLES = 4;
    localparam int REG_AW     = 5;

`ifdef PIPE_HAZARD_PERF_EN
    localparam logic [31:0] C_EXP_STALL = 32'd5;
    localparam logic [31:0] C_EXP_FLUSH = 32'd5;
`else
    localparam logic [31:0] C_EXP_STALL = 32'd0;
    localparam logic [31:0] C_EXP_FLUSH = 32'd0;
`endif

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic [REG_AW-1:0] rtE;
    logic              memtoregE;
    logic              divstartE;
    logic              branch_takenD;
    logic              excM;
    logic              stallF;
    logic              stallD;
    logic              stallE;
    logic              flushD;
    logic              flushE;
    logic              flushM;
    logic              exc_redirect;
    logic              div_done;
    logic              busy;
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_flush_cnt;

    logic [8:0] ctl;
    int vectors;
    int fails;

    assign ctl = {stallF, stallD, stallE, flushD, flushE, flushM,
                  exc_redirect, div_done, busy};

    pipe_hazard_ctrl #(
        .DIV_CYCLES (DIV_CYCLES),
        .REG_AW     (REG_AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rsD            (rsD),
        .rtD            (rtD),
        .rtE            (rtE),
        .memtoregE      (memtoregE),
        .divstartE      (divstartE),
        .branch_takenD  (branch_takenD),
        .excM           (excM),
        .stallF         (stallF),
        .stallD         (stallD),
        .stallE         (stallE),
        .flushD         (flushD),
        .flushE         (flushE),
        .flushM         (flushM),
        .exc_redirect   (exc_redirect),
        .div_done       (div_done),
        .busy           (busy),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rsD = '0; rtD = '0; rtE = '0;
        memtoregE = 1'b0; divstartE = 1'b0;
        branch_takenD = 1'b0; excM = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsD = 5'd3; rtD = 5'd3; rtE = 5'd3; memtoregE = 1'b1;
        divstartE = 1'b1; branch_takenD = 1'b1; excM = 1'b1;
        tick(); tick();
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL reset_ctl got %b exp %b", ctl, 9'b0);
        end
        vectors++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            fails++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_stall_cnt, perf_flush_cnt);
        end
        tick();
        rst = 1'b0; idle();
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL post_reset_idle got %b exp %b", ctl, 9'b0);
        end
        tick();
    endtask

    task automatic test_load_use();
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5; rtD = 5'd1;
        #2;
        vectors++;
        if (ctl !== 9'b110_010_000) begin
            fails++; $display("FAIL lu_rs got %b exp %b", ctl, 9'b110_010_000);
        end
        tick(); idle();
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL lu_release got %b exp %b", ctl, 9'b0);
        end
        tick();
        memtoregE = 1'b1; rtE = 5'd0; rsD = 5'd0; rtD = 5'd0;
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL lu_zero_reg got %b exp %b", ctl, 9'b0);
        end
        tick();
        memtoregE = 1'b1; rtE = 5'd7; rsD = 5'd1; rtD = 5'd7;
        #2;
        vectors++;
        if (ctl !== 9'b110_010_000) begin
            fails++; $display("FAIL lu_rt got %b exp %b", ctl, 9'b110_010_000);
        end
        tick();
        memtoregE = 1'b1; rtE = 5'd7; rsD = 5'd3; rtD = 5'd4;
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL lu_nomatch got %b exp %b", ctl, 9'b0);
        end
        tick();
        memtoregE = 1'b0; rtE = 5'd7; rsD = 5'd7; rtD = 5'd7;
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL lu_not_load got %b exp %b", ctl, 9'b0);
        end
        tick(); idle();
    endtask

    task automatic test_branch();
        branch_takenD = 1'b1;
        #2;
        vectors++;
        if (ctl !== 9'b000_100_000) begin
            fails++; $display("FAIL br_taken got %b exp %b", ctl, 9'b000_100_000);
        end
        tick();
        branch_takenD = 1'b1; memtoregE = 1'b1; rtE = 5'd9; rtD = 5'd9; rsD = 5'd2;
        #2;
        vectors++;
        if (ctl !== 9'b110_010_000) begin
            fails++; $display("FAIL br_vs_lu got %b exp %b", ctl, 9'b110_010_000);
        end
        tick(); idle();
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL br_idle got %b exp %b", ctl, 9'b0);
        end
        tick();
    endtask

    task automatic test_divide();
        // Start cycle also carries a taken branch, which must be suppressed.
        divstartE = 1'b1; branch_takenD = 1'b1;
        #2;
        vectors++;
        if (ctl !== 9'b111_001_000) begin
            fails++; $display("FAIL div_start got %b exp %b", ctl, 9'b111_001_000);
        end
        tick();
        for (int i = 0; i < DIV_CYCLES - 1; i++) begin
            #2;
            vectors++;
            if (ctl !== 9'b111_001_001) begin
                fails++; $display("FAIL div_hold%0d got %b exp %b", i, ctl, 9'b111_001_001);
            end
            tick();
        end
        divstartE = 1'b0; branch_takenD = 1'b0;
        #2;
        vectors++;
        if (ctl !== 9'b000_000_011) begin
            fails++; $display("FAIL div_done got %b exp %b", ctl, 9'b000_000_011);
        end
        tick();
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL div_after got %b exp %b", ctl, 9'b0);
        end
        tick();
    endtask

    task automatic test_exc_in_div();
        divstartE = 1'b1;
        tick();
        tick();
        excM = 1'b1;
        #2;
        vectors++;
        if (ctl !== 9'b000_111_001) begin
            fails++; $display("FAIL exc_div_flush got %b exp %b", ctl, 9'b000_111_001);
        end
        tick(); idle();
        #2;
        vectors++;
        if (ctl !== 9'b000_100_101) begin
            fails++; $display("FAIL exc_redirect got %b exp %b", ctl, 9'b000_100_101);
        end
        tick();
        for (int i = 0; i < DIV_CYCLES; i++) begin
            #2;
            vectors++;
            if (ctl !== 9'b000_000_000) begin
                fails++; $display("FAIL exc_div_quiet%0d got %b exp %b", i, ctl, 9'b0);
            end
            tick();
        end
    endtask

    task automatic test_exc_with_div();
        excM = 1'b1; divstartE = 1'b1;
        #2;
        vectors++;
        if (ctl !== 9'b000_111_000) begin
            fails++; $display("FAIL exc_vs_div got %b exp %b", ctl, 9'b000_111_000);
        end
        tick(); idle();
        #2;
        vectors++;
        if (ctl !== 9'b000_100_101) begin
            fails++; $display("FAIL exc_vs_div_redir got %b exp %b", ctl, 9'b000_100_101);
        end
        tick();
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL exc_vs_div_run got %b exp %b", ctl, 9'b0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // Load-use arriving on the div_done cycle stalls that same cycle.
        divstartE = 1'b1;
        for (int i = 0; i < DIV_CYCLES; i++) tick();
        divstartE = 1'b0; memtoregE = 1'b1; rtE = 5'd4; rsD = 5'd4;
        #2;
        vectors++;
        if (ctl !== 9'b110_010_011) begin
            fails++; $display("FAIL done_plus_lu got %b exp %b", ctl, 9'b110_010_011);
        end
        tick(); idle();
        // Reset in the middle of a divide returns straight to RUN.
        divstartE = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #2;
        vectors++;
        if (ctl !== 9'b000_000_000) begin
            fails++; $display("FAIL rst_in_div got %b exp %b", ctl, 9'b0);
        end
        tick();
        rst = 1'b0; idle();
        for (int i = 0; i < DIV_CYCLES; i++) begin
            #2;
            vectors++;
            if (ctl !== 9'b000_000_000) begin
                fails++; $display("FAIL rst_div_quiet%0d got %b exp %b", i, ctl, 9'b0);
            end
            tick();
        end
    endtask

    task automatic test_perf();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // One load-use cycle then a full divide: 5 stall cycles, 5 flush cycles.
        memtoregE = 1'b1; rtE = 5'd6; rsD = 5'd6;
        tick(); idle();
        divstartE = 1'b1;
        for (int i = 0; i < DIV_CYCLES; i++) tick();
        divstartE = 1'b0;
        tick();
        #2;
        vectors++;
        if (perf_stall_cnt !== C_EXP_STALL) begin
            fails++; $display("FAIL perf_stall got %0d exp %0d", perf_stall_cnt, C_EXP_STALL);
        end
        vectors++;
        if (perf_flush_cnt !== C_EXP_FLUSH) begin
            fails++; $display("FAIL perf_flush got %0d exp %0d", perf_flush_cnt, C_EXP_FLUSH);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        vectors++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            fails++; $display("FAIL perf_clear got %0d/%0d exp 0/0", perf_stall_cnt, perf_flush_cnt);
        end
        tick();
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        rst     = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_divide();
        test_exc_in_div();
        test_exc_with_div();
        test_back_to_back();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
